// File: rtl/softcpu_exec.sv
// softcpu_exec: a small multi-cycle execute core.
// Each instruction walks FETCH -> EXEC -> WB, so every instruction sees
// its predecessor's writeback without forwarding or interlocks.
// Operands are either an immediate or a register selected by the low bits
// of the operand field. Results are written back to rd in WB.
module softcpu_exec #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREG   = 16,
    parameter int unsigned ADDR_W = 16,
    localparam int unsigned RSEL_W  = $clog2(NREG),
    localparam int unsigned INSTR_W = 4 + 2 * (1 + DATA_W) + RSEL_W
) (
    input  logic               clock,
    input  logic               reset,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               instr_req,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               flag_carry,
    output logic               flag_zero,
    output logic               halted
);

    // Instruction word layout, MSB first: opcode, A flag, A field,
    // B flag, B field, rd.
    localparam int unsigned OP_LSB = INSTR_W - 4;
    localparam int unsigned AF_BIT = RSEL_W + 2 * DATA_W + 1;
    localparam int unsigned AV_LSB = RSEL_W + DATA_W + 1;
    localparam int unsigned BF_BIT = RSEL_W + DATA_W;
    localparam int unsigned BV_LSB = RSEL_W;

    typedef enum logic [3:0] {
        OpNop  = 4'h0,
        OpAdd  = 4'h1,
        OpSub  = 4'h2,
        OpAnd  = 4'h3,
        OpOr   = 4'h4,
        OpXor  = 4'h5,
        OpMov  = 4'h6,
        OpOut  = 4'h7,
        OpHalt = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StWb,
        StHalt
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   ip_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic                carry_q;
    logic                zero_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                halted_q;

    opcode_e             opcode;
    logic [DATA_W-1:0]   a_field;
    logic [DATA_W-1:0]   b_field;
    logic [RSEL_W-1:0]   rd;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic                sets_flags;
    logic                writes_rd;
    logic                fetch_accept;

    // Decode the latched instruction, fetch operands and evaluate the ALU.
    always_comb begin
        opcode     = opcode_e'(instr_q[OP_LSB +: 4]);
        a_field    = instr_q[AV_LSB +: DATA_W];
        b_field    = instr_q[BV_LSB +: DATA_W];
        rd         = instr_q[RSEL_W-1:0];
        // Register operands ignore the upper bits of the field.
        op_a       = instr_q[AF_BIT] ? regs_q[RSEL_W'(a_field)] : a_field;
        op_b       = instr_q[BF_BIT] ? regs_q[RSEL_W'(b_field)] : b_field;
        sum        = {1'b0, op_a} + {1'b0, op_b};
        // The extra MSB of the difference is the borrow, i.e. A < B.
        diff       = {1'b0, op_a} - {1'b0, op_b};
        alu_res    = '0;
        alu_carry  = 1'b0;
        sets_flags = 1'b0;
        writes_rd  = 1'b0;
        case (opcode)
            OpAdd: begin
                alu_res    = sum[DATA_W-1:0];
                alu_carry  = sum[DATA_W];
                sets_flags = 1'b1;
                writes_rd  = 1'b1;
            end
            OpSub: begin
                alu_res    = diff[DATA_W-1:0];
                alu_carry  = diff[DATA_W];
                sets_flags = 1'b1;
                writes_rd  = 1'b1;
            end
            OpAnd: begin
                alu_res    = op_a & op_b;
                sets_flags = 1'b1;
                writes_rd  = 1'b1;
            end
            OpOr: begin
                alu_res    = op_a | op_b;
                sets_flags = 1'b1;
                writes_rd  = 1'b1;
            end
            OpXor: begin
                alu_res    = op_a ^ op_b;
                sets_flags = 1'b1;
                writes_rd  = 1'b1;
            end
            OpMov: begin
                alu_res   = op_a;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // Requests are masked while reset is high so the first cycle after
    // release already carries a request.
    assign instr_req    = (state_q == StFetch) && !reset;
    assign fetch_accept = instr_req && instr_valid;

    // Instruction sequencer, register file, flags and output strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StFetch;
            ip_q        <= '0;
            instr_q     <= '0;
            result_q    <= '0;
            regs_q      <= '{default: '0};
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    if (fetch_accept) begin
                        instr_q <= instr_data;
                        ip_q    <= ip_q + ADDR_W'(1);
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (opcode == OpHalt) begin
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else begin
                        result_q <= alu_res;
                        if (sets_flags) begin
                            carry_q <= alu_carry;
                            zero_q  <= (alu_res == '0);
                        end
                        // Strobe lands in the WB cycle; data holds until next OUT.
                        if (opcode == OpOut) begin
                            out_data_q  <= op_a;
                            out_valid_q <= 1'b1;
                        end
                        state_q <= StWb;
                    end
                end
                StWb: begin
                    if (writes_rd) begin
                        regs_q[rd] <= result_q;
                    end
                    state_q <= StFetch;
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign instr_addr = ip_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign flag_carry = carry_q;
    assign flag_zero  = zero_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_softcpu_exec.sv
// Bench for softcpu_exec: directed vector table, corner-case sequences,
// and random instructions checked against a register-file model.
module tb_softcpu_exec;

    localparam int IW1 = 26;
    localparam int IW2 = 41;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance: DATA_W=8, NREG=16, ADDR_W=16.
    logic [15:0]    addr1;
    logic           req1, vld1, ov1, c1, z1, h1;
    logic [IW1-1:0] data1;
    logic [7:0]     od1;

    // Wide-data, short-IP instance: DATA_W=16, NREG=8, ADDR_W=4.
    logic [3:0]     addr2;
    logic           req2, vld2, ov2, c2, z2, h2;
    logic [IW2-1:0] data2;
    logic [15:0]    od2;

    softcpu_exec dut (
        .clock(clk), .reset(rst), .instr_addr(addr1), .instr_req(req1),
        .instr_valid(vld1), .instr_data(data1), .out_data(od1), .out_valid(ov1),
        .flag_carry(c1), .flag_zero(z1), .halted(h1)
    );

    softcpu_exec #(.DATA_W(16), .NREG(8), .ADDR_W(4)) dut2 (
        .clock(clk), .reset(rst), .instr_addr(addr2), .instr_req(req2),
        .instr_valid(vld2), .instr_data(data2), .out_data(od2), .out_valid(ov2),
        .flag_carry(c2), .flag_zero(z2), .halted(h2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ovcnt1 = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ov1 === 1'b1) ovcnt1 <= ovcnt1 + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW1-1:0] enc1(input logic [3:0] op, input logic af,
                                            input logic [7:0] a, input logic bf,
                                            input logic [7:0] b, input logic [3:0] rd);
        return {op, af, a, bf, b, rd};
    endfunction

    function automatic logic [IW2-1:0] enc2(input logic [3:0] op, input logic af,
                                            input logic [15:0] a, input logic bf,
                                            input logic [15:0] b, input logic [2:0] rd);
        return {op, af, a, bf, b, rd};
    endfunction

    // Samples taken during the most recent instruction.
    logic       s_ov, s_c, s_z, s_req_exec, s_req_wb;
    logic [7:0] s_od;
    int         acc_cyc;

    // Present one instruction; return at the negedge after WB (back in FETCH).
    task automatic run1(input logic [IW1-1:0] w);
        int n = 0;
        while (req1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_wait1", 32'(req1), 32'(1'b1));
        acc_cyc = cyc;
        vld1 = 1'b1;
        data1 = w;
        @(negedge clk);
        vld1 = 1'b0;
        s_req_exec = req1;
        @(negedge clk);
        s_req_wb = req1;
        s_ov = ov1;
        s_od = od1;
        s_c = c1;
        s_z = z1;
        @(negedge clk);
    endtask

    logic        s2_ov, s2_c, s2_z;
    logic [15:0] s2_od;

    task automatic run2(input logic [IW2-1:0] w);
        int n = 0;
        while (req2 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_wait2", 32'(req2), 32'(1'b1));
        vld2 = 1'b1;
        data2 = w;
        @(negedge clk);
        vld2 = 1'b0;
        @(negedge clk);
        s2_ov = ov2;
        s2_od = od2;
        s2_c = c2;
        s2_z = z2;
        @(negedge clk);
    endtask

    // Reference model: architectural registers, flags and last OUT value.
    int m_regs [16];
    int m_c, m_z, m_ov, m_od;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_c = 0; m_z = 0; m_ov = 0; m_od = 0;
    endtask

    task automatic model_step(input int op, input int af, input int a, input int bf,
                              input int b, input int rd);
        int va, vb, r;
        va = (af != 0) ? m_regs[a % 16] : a;
        vb = (bf != 0) ? m_regs[b % 16] : b;
        m_ov = 0;
        r = 0;
        case (op)
            1: begin r = va + vb; m_c = (r > 255) ? 1 : 0; r = r % 256; end
            2: begin m_c = (va < vb) ? 1 : 0; r = (va - vb + 256) % 256; end
            3: begin r = va & vb; m_c = 0; end
            4: begin r = va | vb; m_c = 0; end
            5: begin r = va ^ vb; m_c = 0; end
            6: m_regs[rd] = va;
            7: begin m_ov = 1; m_od = va; end
            default: ;
        endcase
        if (op >= 1 && op <= 5) begin
            m_z = (r == 0) ? 1 : 0;
            m_regs[rd] = r;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vld1 = 1'b0;
        vld2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] op;
        logic       af;
        logic [7:0] a;
        logic       bf;
        logic [7:0] b;
        logic [3:0] rd;
        logic       ov;
        logic [7:0] od;
        logic       c;
        logic       z;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    initial begin
        logic [15:0] a0;
        int last;
        int ov_before;

        // Expected state after each row; starts from r3=44, C=1, Z=0.
        vecs[0]  = '{4'h7, 1'b1, 8'd3,   1'b0, 8'd0,   4'd0, 1'b1, 8'd44,  1'b1, 1'b0};
        vecs[1]  = '{4'h6, 1'b0, 8'd5,   1'b0, 8'd0,   4'd0, 1'b0, 8'd44,  1'b1, 1'b0};
        vecs[2]  = '{4'h2, 1'b1, 8'd0,   1'b0, 8'd5,   4'd1, 1'b0, 8'd44,  1'b0, 1'b1};
        vecs[3]  = '{4'h7, 1'b1, 8'd1,   1'b0, 8'd0,   4'd0, 1'b1, 8'd0,   1'b0, 1'b1};
        vecs[4]  = '{4'h3, 1'b0, 8'hF0,  1'b0, 8'h0F,  4'd2, 1'b0, 8'd0,   1'b0, 1'b1};
        vecs[5]  = '{4'h4, 1'b1, 8'd3,   1'b0, 8'h80,  4'd4, 1'b0, 8'd0,   1'b0, 1'b0};
        vecs[6]  = '{4'h7, 1'b1, 8'd4,   1'b0, 8'd0,   4'd0, 1'b1, 8'd172, 1'b0, 1'b0};
        vecs[7]  = '{4'h2, 1'b0, 8'd3,   1'b0, 8'd5,   4'd5, 1'b0, 8'd172, 1'b1, 1'b0};
        vecs[8]  = '{4'h7, 1'b1, 8'd5,   1'b0, 8'd0,   4'd0, 1'b1, 8'd254, 1'b1, 1'b0};
        vecs[9]  = '{4'h1, 1'b1, 8'd5,   1'b1, 8'd5,   4'd5, 1'b0, 8'd254, 1'b1, 1'b0};
        vecs[10] = '{4'h7, 1'b1, 8'h35,  1'b0, 8'd0,   4'd0, 1'b1, 8'd252, 1'b1, 1'b0};
        vecs[11] = '{4'h5, 1'b1, 8'd4,   1'b0, 8'hAC,  4'd6, 1'b0, 8'd252, 1'b0, 1'b1};
        vecs[12] = '{4'hA, 1'b0, 8'hFF,  1'b0, 8'h12,  4'd6, 1'b0, 8'd252, 1'b0, 1'b1};
        vecs[13] = '{4'h6, 1'b1, 8'd3,   1'b0, 8'd0,   4'd7, 1'b0, 8'd252, 1'b0, 1'b1};
        vecs[14] = '{4'h7, 1'b1, 8'd7,   1'b0, 8'd0,   4'd0, 1'b1, 8'd44,  1'b0, 1'b1};
        vecs[15] = '{4'h1, 1'b0, 8'hFF,  1'b0, 8'd1,   4'd8, 1'b0, 8'd44,  1'b1, 1'b1};
        vecs[16] = '{4'h4, 1'b0, 8'd1,   1'b0, 8'd0,   4'd9, 1'b0, 8'd44,  1'b0, 1'b0};
        vecs[17] = '{4'h7, 1'b1, 8'd0,   1'b0, 8'd0,   4'd0, 1'b1, 8'd5,   1'b0, 1'b0};
        vecs[18] = '{4'h7, 1'b1, 8'd6,   1'b0, 8'd0,   4'd0, 1'b1, 8'd0,   1'b0, 1'b0};

        rst = 1'b1;
        vld1 = 1'b0;
        vld2 = 1'b0;
        data1 = '0;
        data2 = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_req", 32'(req1), 32'(1'b0));
        chk("rst_addr", 32'(addr1), 32'd0);
        chk("rst_flags", 32'({c1, z1}), 32'(2'b00));
        chk("rst_out", 32'({ov1, od1}), 32'd0);
        chk("rst_halted", 32'(h1), 32'(1'b0));
        rst = 1'b0;
        model_reset();
        #1;
        chk("req_after_rst", 32'(req1), 32'(1'b1));

        // ADD imm 200 + imm 100 -> r3.
        chk("add_addr_pre", 32'(addr1), 32'd0);
        run1(enc1(4'h1, 1'b0, 8'd200, 1'b0, 8'd100, 4'd3));
        chk("add_addr_post", 32'(addr1), 32'd1);
        chk("add_flags", 32'({s_c, s_z}), 32'(2'b10));
        chk("add_no_out", 32'(s_ov), 32'(1'b0));
        chk("req_low_exec_wb", 32'({s_req_exec, s_req_wb}), 32'(2'b00));

        for (int i = 0; i < NVEC; i++) begin
            run1(enc1(vecs[i].op, vecs[i].af, vecs[i].a, vecs[i].bf, vecs[i].b, vecs[i].rd));
            chk($sformatf("vec%0d_ov", i), 32'(s_ov), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_od", i), 32'(s_od), 32'(vecs[i].od));
            chk($sformatf("vec%0d_flags", i), 32'({s_c, s_z}), 32'({vecs[i].c, vecs[i].z}));
        end

        // Stall in FETCH for 4 cycles.
        a0 = addr1;
        ov_before = ovcnt1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_req", 32'(req1), 32'(1'b1));
            chk("stall_addr", 32'(addr1), 32'(a0));
            @(negedge clk);
        end
        chk("stall_no_out", 32'(ovcnt1 - ov_before), 32'd0);

        // Back-to-back NOPs: one acceptance every 3 cycles.
        run1(enc1(4'h0, 1'b0, 8'd0, 1'b0, 8'd0, 4'd0));
        last = acc_cyc;
        for (int i = 0; i < 3; i++) begin
            run1(enc1(4'h0, 1'b0, 8'd0, 1'b0, 8'd0, 4'd0));
            chk("throughput", 32'(acc_cyc - last), 32'd3);
            last = acc_cyc;
        end
        chk("nop_addr", 32'(addr1), 32'(a0 + 16'd4));

        // Random instructions against the model.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int op, af, a, bf, b, rd;
            op = int'($urandom_range(0, 14));
            if ($urandom_range(0, 2) == 0) op = 7;
            af = int'($urandom_range(0, 1));
            bf = int'($urandom_range(0, 1));
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            rd = int'($urandom_range(0, 15));
            model_step(op, af, a, bf, b, rd);
            run1(enc1(4'(op), 1'(af), 8'(a), 1'(bf), 8'(b), 4'(rd)));
            chk($sformatf("rnd%0d_ov", i), 32'(s_ov), 32'(m_ov));
            chk($sformatf("rnd%0d_od", i), 32'(s_od), 32'(m_od));
            chk($sformatf("rnd%0d_c", i), 32'(s_c), 32'(m_c));
            chk($sformatf("rnd%0d_z", i), 32'(s_z), 32'(m_z));
        end

        // Reset beats a simultaneous fetch acceptance.
        chk("ovr_ip_nonzero", 32'(addr1 != 16'd0), 32'd1);
        vld1 = 1'b1;
        data1 = enc1(4'h6, 1'b0, 8'd1, 1'b0, 8'd0, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ovr_addr", 32'(addr1), 32'd0);
        chk("ovr_req", 32'(req1), 32'(1'b0));
        rst = 1'b0;
        vld1 = 1'b0;
        #1;
        chk("ovr_req_after", 32'(req1), 32'(1'b1));
        @(negedge clk);
        run1(enc1(4'h7, 1'b1, 8'd0, 1'b0, 8'd0, 4'd0));
        chk("ovr_r0", 32'(s_od), 32'd0);

        // Reset during EXEC of OUT: no strobe.
        run1(enc1(4'h6, 1'b0, 8'd77, 1'b0, 8'd0, 4'd4));
        ov_before = ovcnt1;
        vld1 = 1'b1;
        data1 = enc1(4'h7, 1'b1, 8'd4, 1'b0, 8'd0, 4'd0);
        @(negedge clk);
        vld1 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("exec_rst_no_out", 32'(ovcnt1 - ov_before), 32'd0);
        chk("exec_rst_od", 32'(od1), 32'd0);

        // Reset during WB of MOV imm 9 -> r2.
        ov_before = ovcnt1;
        vld1 = 1'b1;
        data1 = enc1(4'h6, 1'b0, 8'd9, 1'b0, 8'd0, 4'd2);
        @(negedge clk);
        vld1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("wb_rst_no_out", 32'(ovcnt1 - ov_before), 32'd0);
        run1(enc1(4'h7, 1'b1, 8'd2, 1'b0, 8'd0, 4'd0));
        chk("wb_rst_r2", 32'(s_od), 32'd0);

        // HALT is terminal until reset.
        run1(enc1(4'h1, 1'b0, 8'd200, 1'b0, 8'd100, 4'd1));
        run1(enc1(4'hF, 1'b0, 8'd0, 1'b0, 8'd0, 4'd0));
        a0 = addr1;
        ov_before = ovcnt1;
        vld1 = 1'b1;
        data1 = enc1(4'h1, 1'b0, 8'd0, 1'b0, 8'd0, 4'd1);
        for (int i = 0; i < 5; i++) begin
            chk("halt_state", 32'({h1, req1}), 32'(2'b10));
            chk("halt_addr", 32'(addr1), 32'(a0));
            chk("halt_flags", 32'({c1, z1}), 32'(2'b10));
            @(negedge clk);
        end
        chk("halt_no_out", 32'(ovcnt1 - ov_before), 32'd0);
        do_reset();
        chk("halt_rst", 32'({h1, addr1}), 32'd0);
        run1(enc1(4'h7, 1'b1, 8'd1, 1'b0, 8'd0, 4'd0));
        chk("halt_rst_r1", 32'(s_od), 32'd0);

        // Wide instance: IP wrap with ADDR_W=4, then 16-bit carry.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            run2(enc2(4'h0, 1'b0, 16'd0, 1'b0, 16'd0, 3'd0));
            if (i == 14) chk("wrap_ip15", 32'(addr2), 32'd15);
        end
        chk("wrap_ip0", 32'(addr2), 32'd0);
        run2(enc2(4'h1, 1'b0, 16'hFFFF, 1'b0, 16'd1, 3'd7));
        chk("w16_flags", 32'({s2_c, s2_z}), 32'(2'b11));
        run2(enc2(4'h6, 1'b0, 16'h1234, 1'b0, 16'd0, 3'd6));
        run2(enc2(4'h7, 1'b1, 16'd7, 1'b0, 16'd0, 3'd0));
        chk("w16_r7", 32'({s2_ov, s2_od}), 32'h10000);
        run2(enc2(4'h7, 1'b1, 16'd6, 1'b0, 16'd0, 3'd0));
        chk("w16_r6", 32'({s2_ov, s2_od}), 32'h11234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
